// File: rtl/data_store_fifo.sv
// Committed-store buffer: in-order FIFO between commit and the data-memory write port.
// Optional store/load overlap detection is enabled by defining DATA_STORE_FIFO_HAZARD_EN.
module data_store_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             datafifo_valid_in,
  input  logic [31:0]      datafifo_addr_in,
  input  logic [31:0]      datafifo_val_in,
  input  logic [1:0]       datafifo_size_in,
  output logic             datafifo_full,
  output logic [31:0]      mem_store_addr,
  output logic [31:0]      mem_store_val,
  output logic [1:0]       mem_store_size,
  output logic             mem_store_valid,
  input  logic             mem_store_ready,
  output logic             empty,
  output logic [PTR_W:0]   count,
  input  logic [31:0]      hazard_addr,
  output logic             hazard_hit
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      val_q  [DEPTH];
  logic [1:0]       size_q [DEPTH];
  logic             push, pop;

  // Status comes from the registered count only; a same-cycle pop never frees a slot for a push.
  assign datafifo_full   = (count_q == (PTR_W+1)'(DEPTH));
  assign empty           = (count_q == '0);
  assign count           = count_q;
  assign mem_store_valid = ~empty;
  assign mem_store_addr  = addr_q[rd_ptr_q];
  assign mem_store_val   = val_q[rd_ptr_q];
  assign mem_store_size  = size_q[rd_ptr_q];

  assign push = datafifo_valid_in & ~datafifo_full;
  assign pop  = mem_store_valid & mem_store_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        val_q[i]  <= '0;
        size_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        addr_q[wr_ptr_q] <= datafifo_addr_in;
        val_q[wr_ptr_q]  <= datafifo_val_in;
        size_q[wr_ptr_q] <= datafifo_size_in;
      end
    end
  end

`ifdef DATA_STORE_FIFO_HAZARD_EN
  logic [PTR_W-1:0] slot_off;
  logic [1:0]       unused_hazard_lsb;
  assign unused_hazard_lsb = hazard_addr[1:0];

  // A slot is occupied when its distance from the head is below the registered count.
  always_comb begin
    hazard_hit = 1'b0;
    slot_off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, slot_off} < count_q) && (addr_q[i][31:2] == hazard_addr[31:2]))
        hazard_hit = 1'b1;
    end
  end
`else
  logic [31:0] unused_hazard_addr;
  assign unused_hazard_addr = hazard_addr;
  assign hazard_hit         = 1'b0;
`endif

endmodule

// File: tb/tb_data_store_fifo.sv
// Bench for data_store_fifo: queue-based reference model checked every cycle, plus directed scenarios.
module tb_data_store_fifo;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] v;
    logic [1:0]  s;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        datafifo_valid_in = 1'b0;
  logic [31:0] datafifo_addr_in = '0;
  logic [31:0] datafifo_val_in = '0;
  logic [1:0]  datafifo_size_in = '0;
  logic        datafifo_full;
  logic [31:0] mem_store_addr;
  logic [31:0] mem_store_val;
  logic [1:0]  mem_store_size;
  logic        mem_store_valid;
  logic        mem_store_ready = 1'b0;
  logic        empty;
  logic [2:0]  count;
  logic [31:0] hazard_addr = '0;
  logic        hazard_hit;

  ent_t mq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  data_store_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .datafifo_valid_in(datafifo_valid_in), .datafifo_addr_in(datafifo_addr_in),
    .datafifo_val_in(datafifo_val_in), .datafifo_size_in(datafifo_size_in),
    .datafifo_full(datafifo_full),
    .mem_store_addr(mem_store_addr), .mem_store_val(mem_store_val),
    .mem_store_size(mem_store_size), .mem_store_valid(mem_store_valid),
    .mem_store_ready(mem_store_ready),
    .empty(empty), .count(count),
    .hazard_addr(hazard_addr), .hazard_hit(hazard_hit)
  );

  always #5 clk = ~clk;

  // Commit must never push while the buffer reports full.
  always @(posedge clk) begin
    if (!reset)
      assert (!(datafifo_valid_in && datafifo_full)) else $error("protocol violation: push while full");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic exp_hit;
    exp_hit = 1'b0;
    chk("valid", 32'(mem_store_valid), 32'(mq.size() != 0));
    chk("count", 32'(count), 32'(mq.size()));
    chk("full",  32'(datafifo_full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    if (mq.size() != 0) begin
      chk("head_addr", mem_store_addr, mq[0].a);
      chk("head_val",  mem_store_val,  mq[0].v);
      chk("head_size", 32'(mem_store_size), 32'(mq[0].s));
    end
`ifdef DATA_STORE_FIFO_HAZARD_EN
    foreach (mq[i]) if (mq[i].a[31:2] == hazard_addr[31:2]) exp_hit = 1'b1;
`endif
    chk("hazard", 32'(hazard_hit), 32'(exp_hit));
  endtask

  // One clock: check current outputs, advance model with the inputs held across the edge.
  task automatic step();
    bit   do_push, do_pop;
    ent_t e;
    check_outputs();
    do_push = datafifo_valid_in && (mq.size() < DEPTH);
    do_pop  = (mq.size() != 0) && mem_store_ready;
    e = '{a: datafifo_addr_in, v: datafifo_val_in, s: datafifo_size_in};
    @(posedge clk);
    if (reset) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic set_push(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
    datafifo_valid_in = 1'b1;
    datafifo_addr_in  = a;
    datafifo_val_in   = v;
    datafifo_size_in  = s;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    datafifo_valid_in = 1'b0;
    mem_store_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Power-on reset without model checks: DUT state is unknown before the first edge.
    @(posedge clk);
    #1;
    mq.delete();
    reset = 1'b0;
    chk("rst_valid", 32'(mem_store_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(datafifo_full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_addr",  mem_store_addr, 32'd0);
    chk("rst_val",   mem_store_val, 32'd0);
    chk("rst_size",  32'(mem_store_size), 32'd0);
    chk("rst_hit",   32'(hazard_hit), 32'd0);

    // Single push with ready low: visible next cycle, held while not accepted.
    set_push(32'h100, 32'hDEADBEEF, 2'd2);
    step();
    datafifo_valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t1_valid", 32'(mem_store_valid), 32'd1);
      chk("t1_addr",  mem_store_addr, 32'h100);
      chk("t1_val",   mem_store_val, 32'hDEADBEEF);
      chk("t1_size",  32'(mem_store_size), 32'd2);
      chk("t1_count", 32'(count), 32'd1);
      step();
    end

    // Fill to full, then drain in order.
    for (int k = 0; k < 3; k++) begin
      set_push(32'h200 + 32'(k * 4), 32'hA000_0000 + 32'(k), 2'(k));
      step();
    end
    datafifo_valid_in = 1'b0;
    chk("t2_full",  32'(datafifo_full), 32'd1);
    chk("t2_count", 32'(count), 32'd4);
    mem_store_ready = 1'b1;
    chk("t2_head0", mem_store_addr, 32'h100);
    step();
    chk("t2_head1", mem_store_addr, 32'h200);
    chk("t2_full_drop", 32'(datafifo_full), 32'd0);
    for (int k = 0; k < 3; k++) step();
    chk("t2_empty", 32'(empty), 32'd1);
    mem_store_ready = 1'b0;

    // Simultaneous push/pop at count 2, long enough to wrap the pointers.
    for (int k = 0; k < 2; k++) begin
      set_push(32'h300 + 32'(k * 4), 32'hB000_0000 + 32'(k), 2'd2);
      step();
    end
    mem_store_ready = 1'b1;
    for (int k = 2; k < 12; k++) begin
      set_push(32'h300 + 32'(k * 4), 32'hB000_0000 + 32'(k), 2'd3);
      step();
      chk("t3_count", 32'(count), 32'd2);
    end
    chk("t3_head", mem_store_val, 32'hB000_000A);
    datafifo_valid_in = 1'b0;

    // Reset while draining.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_push(32'h400 + 32'(k * 4), 32'(k), 2'd2);
      step();
    end
    datafifo_valid_in = 1'b0;
    mem_store_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t4_valid", 32'(mem_store_valid), 32'd0);
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_empty", 32'(empty), 32'd1);
    chk("t4_full",  32'(datafifo_full), 32'd0);
    for (int k = 0; k < 3; k++) step();

`ifdef DATA_STORE_FIFO_HAZARD_EN
    // Word-granular overlap against queued stores.
    mem_store_ready = 1'b0;
    set_push(32'h204, 32'h11, 2'd0);
    step();
    datafifo_valid_in = 1'b0;
    hazard_addr = 32'h206;
    #1 chk("t5_hit_same_word", 32'(hazard_hit), 32'd1);
    hazard_addr = 32'h208;
    #1 chk("t5_miss_next_word", 32'(hazard_hit), 32'd0);
    hazard_addr = 32'h206;
    mem_store_ready = 1'b1;
    #1 chk("t5_hit_while_pop", 32'(hazard_hit), 32'd1);
    step();
    chk("t5_miss_after_pop", 32'(hazard_hit), 32'd0);
`endif

    // Push into empty with ready held: one-cycle latency, popped immediately.
    do_reset();
    mem_store_ready = 1'b1;
    set_push(32'h500, 32'hCAFEF00D, 2'd1);
    step();
    datafifo_valid_in = 1'b0;
    chk("t6_valid", 32'(mem_store_valid), 32'd1);
    chk("t6_addr",  mem_store_addr, 32'h500);
    step();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);

    // Randomized traffic with occasional resets and varying drain pressure.
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom_range(0, 249) == 0);
      if ((mq.size() < DEPTH) && ($urandom_range(0, 2) != 0))
        set_push(32'h1000 + 32'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)));
      else
        datafifo_valid_in = 1'b0;
      if (k < 1000)      mem_store_ready = ($urandom_range(0, 3) == 0);
      else if (k < 2000) mem_store_ready = ($urandom_range(0, 3) != 0);
      else               mem_store_ready = $urandom_range(0, 1) != 0;
      hazard_addr = 32'h1000 + 32'($urandom_range(0, 63));
      #1;
      step();
    end
    reset = 1'b0;
    datafifo_valid_in = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
